// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a common-anode hex display: one nibble per refresh slot,
// double-buffered value so new data only shows from the start of a frame.
module display_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [3:0]            bin,
  output logic [DIGITS-1:0]     anode,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [3:0]          bin_q, bin_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                frame_end;
  logic                zero_above;
  logic [DIGITS-1:0]   blank_vec;

  assign tick      = (presc_q == LAST_CNT);
  assign frame_end = tick && (idx_q == LAST_IDX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the pending buffer.
  always_comb begin
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    frame_done_d = frame_end;
    if (frame_end) begin
      if (load) begin
        act_val_d    = value;
        act_dp_d     = dp_mask;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end
  end

  // Digit d blanks when it and every more significant nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_above   = zero_above & (act_val_q[4*d +: 4] == 4'h0);
      blank_vec[d] = blank_lz & zero_above;
    end
  end

  always_comb begin
    bin_d   = 4'h0;
    anode_d = '1;
    dp_d    = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if ((int'(idx_q) == d) && !blank_vec[d]) begin
        anode_d[d] = 1'b0;
        bin_d      = act_val_q[4*d +: 4];
        dp_d       = ~act_dp_q[d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      bin_q        <= 4'h0;
      anode_q      <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      bin_q        <= bin_d;
      anode_q      <= anode_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bin        = bin_q;
  assign anode      = anode_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: directed loads plus random traffic, compared every cycle
// against a time-based reference model of the scan and the frame-boundary buffering.
module tb_display_scanner;

  localparam int D     = 4;
  localparam int RD    = 4;
  localparam int FRAME = D * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  bin;
  logic [3:0]  anode;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: t counts clock edges since reset release.
  int          t;
  logic [15:0] m_act_v, m_pend_v;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pend_ok;
  logic [9:0]  exp_q[$];

  display_scanner #(.DIGITS(D), .REFRESH_DIV(RD), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .bin        (bin),
    .anode      (anode),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    m_act_v   = '0;
    m_act_dp  = '0;
    m_pend_v  = '0;
    m_pend_dp = '0;
    m_pend_ok = 1'b0;
  endtask

  // Expected outputs after this edge are {frame_done, dp, anode, bin}.
  task automatic model_edge();
    int         dig;
    logic       fd;
    logic       dpx;
    logic [3:0] an;
    logic [3:0] b;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back({1'b0, 1'b1, 4'hF, 4'h0});
    end else begin
      dig = (t / RD) % D;
      fd  = ((t % FRAME) == FRAME - 1);
      if (dig != 0 && blank_lz && ((m_act_v >> (4 * dig)) == 16'h0)) begin
        an  = 4'hF;
        b   = 4'h0;
        dpx = 1'b1;
      end else begin
        an  = ~(4'b0001 << dig);
        b   = 4'(m_act_v >> (4 * dig));
        dpx = ~m_act_dp[dig];
      end
      exp_q.push_back({fd, dpx, an, b});
      if (fd) begin
        if (load) begin
          m_act_v   = value;
          m_act_dp  = dp_mask;
          m_pend_ok = 1'b0;
        end else if (m_pend_ok) begin
          m_act_v   = m_pend_v;
          m_act_dp  = m_pend_dp;
          m_pend_ok = 1'b0;
        end
      end else if (load) begin
        m_pend_v  = value;
        m_pend_dp = dp_mask;
        m_pend_ok = 1'b1;
      end
      t++;
    end
  endtask

  task automatic cycle(input int n);
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      e = exp_q.pop_front();
      check("bin", 32'(bin), 32'(e[3:0]));
      check("anode", 32'(anode), 32'(e[7:4]));
      check("dp", 32'(dp), 32'(e[8]));
      check("frame_done", 32'(frame_done), 32'(e[9]));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    value   = v;
    dp_mask = m;
    load    = 1'b1;
    cycle(1);
    load    = 1'b0;
  endtask

  // Advance until the next edge falls at the given position within the frame.
  task automatic wait_phase(input int p);
    logic found;
    found = 1'b0;
    for (int i = 0; i <= FRAME; i++) begin
      if ((t % FRAME) == p) begin
        found = 1'b1;
        break;
      end
      cycle(1);
    end
    check("wait_phase_bound", 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bin"}, 32'(bin), 32'h0);
    check({tag, "_anode"}, 32'(anode), 32'hF);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    logic [15:0] rv;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    #1;
    check_reset_outputs("rst_release");

    // Plain scan of zero, several frames.
    cycle(40);

    // Mid-frame load waits for the boundary.
    wait_phase(4);
    do_load(16'hBEEF, 4'h0);
    cycle(40);

    // Load exactly on the last digit's tick goes straight to active.
    wait_phase(FRAME - 1);
    do_load(16'h1234, 4'h0);
    cycle(20);

    // Two loads in one frame: the last one wins.
    wait_phase(2);
    do_load(16'h1111, 4'h0);
    cycle(3);
    do_load(16'h2222, 4'h0);
    cycle(30);

    // Leading-zero blanking, including dp suppressed on blank digits.
    blank_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    cycle(40);
    do_load(16'h0000, 4'hF);
    cycle(40);
    blank_lz = 1'b0;
    cycle(20);

    do_load(16'h1234, 4'b0100);
    cycle(40);

    // Random loads, masks and live blanking changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 7) == 0) begin
        rv = 16'($urandom);
        rv = rv >> (4 * $urandom_range(0, 4));
        do_load(rv, 4'($urandom_range(0, 15)));
      end else begin
        cycle(1);
      end
    end

    // Async reset mid-frame with a pending value that must be discarded.
    blank_lz = 1'b0;
    wait_phase(6);
    do_load(16'hDEAD, 4'hF);
    cycle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    cycle(3);
    rst_n = 1'b1;
    cycle(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
